// File: rtl/fp_normalizer_pipe.sv
// Two-stage fraction normalizer: overflow shift with sticky jam, leading-zero left shift, zero detect.
// Optional exponent clamp for subnormal alignment is enabled by defining FP_NORMALIZER_DENORM_CLAMP_EN.
module fp_normalizer_pipe #(
    parameter int EXP_WIDTH  = 10,
    parameter int FRAC_WIDTH = 49,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_WIDTH-1:0]  in_exponent,
    input  logic [FRAC_WIDTH-1:0] in_fraction,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  out_exponent,
    output logic [FRAC_WIDTH-1:0] out_fraction,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_zero,
    output logic                  out_underflow
);

    localparam int M   = FRAC_WIDTH - 1;
    localparam int LZW = $clog2(FRAC_WIDTH);
    localparam int CW  = ((EXP_WIDTH > LZW) ? EXP_WIDTH : LZW) + 1;

    typedef enum logic [1:0] {
        CASE_NORM  = 2'd0,
        CASE_OVF   = 2'd1,
        CASE_UNDER = 2'd2,
        CASE_ZERO  = 2'd3
    } norm_case_e;

    logic                  s1_valid_q;
    norm_case_e            s1_case_q,  s1_case_d;
    logic [FRAC_WIDTH-1:0] s1_frac_q;
    logic [EXP_WIDTH-1:0]  s1_exp_q;
    logic [TAG_WIDTH-1:0]  s1_tag_q;
    logic [LZW-1:0]        s1_shift_q, s1_shift_d;
    logic                  s1_uf_q,    s1_uf_d;

    logic                  s2_valid_q;
    logic [FRAC_WIDTH-1:0] s2_frac_q,  s2_frac_d;
    logic [EXP_WIDTH-1:0]  s2_exp_q,   s2_exp_d;
    logic [TAG_WIDTH-1:0]  s2_tag_q;
    logic                  s2_zero_q,  s2_zero_d;
    logic                  s2_uf_q,    s2_uf_d;

    logic           s1_load, s2_load;
    logic [LZW-1:0] lz;
    logic [CW-1:0]  e_ext, e_m1, l_ext;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    // Reset flushes the pipe on the next edge, so advertise space while it is held.
    assign in_ready = s1_load || reset;

    // Stage 1 decode: leading-zero count over F[M-1:0] and the shift amount.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lz = LZW'(M);
        for (int i = 0; i < M; i++) begin
            if (in_fraction[i]) lz = LZW'(M - 1 - i);
        end
        e_ext = CW'(in_exponent);
        e_m1  = e_ext - CW'(1);
        l_ext = CW'(lz);

        if (in_fraction[M])             s1_case_d = CASE_OVF;
        else if (in_fraction[M-1])      s1_case_d = CASE_NORM;
        else if (in_fraction == '0)     s1_case_d = CASE_ZERO;
        else                            s1_case_d = CASE_UNDER;

        s1_shift_d = '0;
        s1_uf_d    = 1'b0;
        if (s1_case_d == CASE_UNDER) begin
`ifdef FP_NORMALIZER_DENORM_CLAMP_EN
            if (e_ext == '0)        s1_shift_d = '0;
            else if (l_ext < e_m1)  s1_shift_d = lz;
            else                    s1_shift_d = LZW'(e_m1);
            s1_uf_d = (CW'(s1_shift_d) < l_ext);
`else
            s1_shift_d = lz;
            s1_uf_d    = (e_ext < l_ext);
`endif
        end
    end

    always_comb begin
        s2_frac_d = s1_frac_q;
        s2_exp_d  = s1_exp_q;
        s2_zero_d = 1'b0;
        s2_uf_d   = 1'b0;
        case (s1_case_q)
            CASE_OVF: begin
                s2_frac_d = {1'b0, s1_frac_q[M:2], s1_frac_q[1] | s1_frac_q[0]};
                s2_exp_d  = s1_exp_q + EXP_WIDTH'(1);
            end
            CASE_UNDER: begin
                s2_frac_d = s1_frac_q << s1_shift_q;
                s2_exp_d  = s1_exp_q - EXP_WIDTH'(s1_shift_q);
                s2_uf_d   = s1_uf_q;
            end
            CASE_ZERO: begin
                s2_frac_d = '0;
                s2_exp_d  = '0;
                s2_zero_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_case_q  <= CASE_NORM;
            s1_frac_q  <= '0;
            s1_exp_q   <= '0;
            s1_tag_q   <= '0;
            s1_shift_q <= '0;
            s1_uf_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_frac_q  <= '0;
            s2_exp_q   <= '0;
            s2_tag_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uf_q    <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_case_q  <= s1_case_d;
                    s1_frac_q  <= in_fraction;
                    s1_exp_q   <= in_exponent;
                    s1_tag_q   <= in_tag;
                    s1_shift_q <= s1_shift_d;
                    s1_uf_q    <= s1_uf_d;
                end
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_frac_q <= s2_frac_d;
                    s2_exp_q  <= s2_exp_d;
                    s2_tag_q  <= s1_tag_q;
                    s2_zero_q <= s2_zero_d;
                    s2_uf_q   <= s2_uf_d;
                end
            end
        end
    end

    assign out_valid     = s2_valid_q;
    assign out_fraction  = s2_frac_q;
    assign out_exponent  = s2_exp_q;
    assign out_tag       = s2_tag_q;
    assign out_zero      = s2_zero_q;
    assign out_underflow = s2_uf_q;

endmodule

// File: tb/tb_fp_normalizer_pipe.sv
// Scoreboard bench for fp_normalizer_pipe: directed vectors, backpressure, reset flush.
// Clamp-dependent expectations follow FP_NORMALIZER_DENORM_CLAMP_EN.
module tb_fp_normalizer_pipe;

    localparam int EW = 10;
    localparam int FW = 49;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] in_exponent;
    logic [FW-1:0] in_fraction;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_exponent;
    logic [FW-1:0] out_fraction;
    logic [TW-1:0] out_tag;
    logic          out_zero;
    logic          out_underflow;

    fp_normalizer_pipe #(.EXP_WIDTH(EW), .FRAC_WIDTH(FW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_exponent(in_exponent), .in_fraction(in_fraction), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exponent(out_exponent), .out_fraction(out_fraction), .out_tag(out_tag),
        .out_zero(out_zero), .out_underflow(out_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FW-1:0] frac;
        logic [EW-1:0] e;
        logic [TW-1:0] tag;
        logic          z;
        logic          uf;
        logic          chk_lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [FW-1:0] b(input int i);
        logic [FW-1:0] one;
        one = 1;
        return one << i;
    endfunction

    task automatic send(input logic [FW-1:0] f, input logic [EW-1:0] e, input logic [TW-1:0] t,
                        input logic [FW-1:0] xf, input logic [EW-1:0] xe,
                        input logic xz, input logic xu, input logic lat);
        exp_t x;
        int   waited;
        in_valid    = 1'b1;
        in_fraction = f;
        in_exponent = e;
        in_tag      = t;
        waited      = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                check("accept_timeout", 64'(waited), 64'(0));
                in_valid = 1'b0;
                return;
            end
        end
        x.frac = xf; x.e = xe; x.tag = t; x.z = xz; x.uf = xu; x.chk_lat = lat; x.acc = cyc;
        sb.push_back(x);
        n_acc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        check(name, 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each output transfer and checks output stability during stalls.
    logic          have_prev = 1'b0;
    logic [FW-1:0] p_frac;
    logic [EW-1:0] p_e;
    logic [TW-1:0] p_tag;
    logic          p_z, p_uf;

    always @(negedge clk) begin
        exp_t x;
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_frac", 64'(out_fraction), 64'(p_frac));
                check("hold_exp", 64'(out_exponent), 64'(p_e));
                check("hold_tag", 64'(out_tag), 64'(p_tag));
                check("hold_flags", 64'({out_zero, out_underflow}), 64'({p_z, p_uf}));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("stale_output_tag", 64'(out_tag), 64'hdead);
                end else begin
                    x = sb.pop_front();
                    check("tag", 64'(out_tag), 64'(x.tag));
                    check("frac", 64'(out_fraction), 64'(x.frac));
                    check("exp", 64'(out_exponent), 64'(x.e));
                    check("zero", 64'(out_zero), 64'(x.z));
                    check("underflow", 64'(out_underflow), 64'(x.uf));
                    if (x.chk_lat) check("latency", 64'(cyc - x.acc), 64'(2));
                end
            end
            have_prev = out_valid && !out_ready;
            p_frac = out_fraction; p_e = out_exponent; p_tag = out_tag;
            p_z = out_zero; p_uf = out_underflow;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_fraction = '0; in_exponent = '0; in_tag = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid2", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'({out_fraction, out_zero, out_underflow}), 64'(0));
        check("rst_out_exp_tag", 64'({out_exponent, out_tag}), 64'(0));
        @(posedge clk); #1;

        // Directed vectors, back-to-back with the consumer always ready.
        send(b(48) | b(0), 10'd100, 4'd1, b(47) | b(0), 10'd101, 1'b0, 1'b0, 1'b1);
        send(b(47) | b(3), 10'd5,   4'd2, b(47) | b(3), 10'd5,   1'b0, 1'b0, 1'b1);
        send(b(44),        10'd100, 4'd3, b(47),        10'd97,  1'b0, 1'b0, 1'b1);
        send('0,           10'd200, 4'd9, '0,           10'd0,   1'b1, 1'b0, 1'b1);
`ifdef FP_NORMALIZER_DENORM_CLAMP_EN
        send(b(40),        10'd4,   4'd5, b(43),        10'd1,   1'b0, 1'b1, 1'b1);
`else
        send(b(40),        10'd4,   4'd5, b(47),        10'd1021, 1'b0, 1'b1, 1'b1);
`endif
        send(b(48) | b(47) | b(1), 10'd1023, 4'd6, b(47) | b(46) | b(0), 10'd0, 1'b0, 1'b0, 1'b1);
        send(b(48) | b(2),  10'd7,  4'd7, b(47) | b(1), 10'd8,   1'b0, 1'b0, 1'b1);
`ifdef FP_NORMALIZER_DENORM_CLAMP_EN
        send(b(0),  10'd47, 4'd8,  b(46), 10'd1, 1'b0, 1'b1, 1'b1);
        send(b(40), 10'd0,  4'd10, b(40), 10'd0, 1'b0, 1'b1, 1'b1);
        send(b(46), 10'd1,  4'd11, b(46), 10'd1, 1'b0, 1'b1, 1'b1);
`else
        send(b(0),  10'd47, 4'd8,  b(47), 10'd0,    1'b0, 1'b0, 1'b1);
        send(b(40), 10'd0,  4'd10, b(47), 10'd1017, 1'b0, 1'b1, 1'b1);
        send(b(46), 10'd1,  4'd11, b(47), 10'd0,    1'b0, 1'b0, 1'b1);
`endif
        send(b(47), 10'd0,  4'd12, b(47), 10'd0, 1'b0, 1'b0, 1'b1);
        drain("drain_directed");

        // Backpressure: consumer stalls while four operations are offered back to back.
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                send(b(47) | b(1), 10'd11, 4'd1, b(47) | b(1), 10'd11, 1'b0, 1'b0, 1'b0);
                send(b(47) | b(2), 10'd12, 4'd2, b(47) | b(2), 10'd12, 1'b0, 1'b0, 1'b0);
                send(b(47) | b(3), 10'd13, 4'd3, b(47) | b(3), 10'd13, 1'b0, 1'b0, 1'b0);
                send(b(47) | b(4), 10'd14, 4'd4, b(47) | b(4), 10'd14, 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 64'(in_ready), 64'(0));
                check("bp_accepts", 64'(n_acc), 64'(2));
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        // Reset with two operations in flight discards them.
        out_ready = 1'b0;
        send(b(47), 10'd21, 4'd13, b(47), 10'd21, 1'b0, 1'b0, 1'b0);
        send(b(47), 10'd22, 4'd14, b(47), 10'd22, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("inflight_valid_before_reset", 64'(out_valid), 64'(1));
        check("in_ready_during_reset", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        check("out_valid_after_reset", 64'(out_valid), 64'(0));
        sb.delete();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("no_stale_after_reset", 64'(out_valid), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_normalizer_pipe.md
# fp_normalizer_pipe

Pipelined, parametrised fraction normalizer for the FPU datapath, sitting between the add/sub/mul/div fraction units and the rounder. It takes a two-integer-bit fraction and its exponent, then normalises the fraction so the leading one lands at bit FRAC_WIDTH-2. It counts leading zeros across the full fractional width, preserves a sticky bit on right shift, flags zero and exponent underflow, and moves results through a two-stage valid/ready pipeline with backpressure and an operation tag.

## Interface
- EXP_WIDTH, 10: exponent width, unsigned.
- FRAC_WIDTH, 49: fraction width in [xx.xxx…] format; 2 integer bits, FRAC_WIDTH-2 fractional bits. Legal range 8..64.
- TAG_WIDTH, 4: opaque tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts the input this cycle.
- in_exponent  in  EXP_WIDTH  calculated exponent.
- in_fraction  in  FRAC_WIDTH  calculated fraction.
- in_tag  in  TAG_WIDTH  operation tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_exponent  out  EXP_WIDTH  normalised exponent.
- out_fraction  out  FRAC_WIDTH  normalised fraction.
- out_tag  out  TAG_WIDTH  tag of the result.
- out_zero  out  1  input fraction was all zero.
- out_underflow  out  1  exponent underflow occurred (see Configuration).

## Operation
Let F = in_fraction, E = in_exponent, and M = FRAC_WIDTH-1.

The block handles four cases, in priority order:
- **Overflow (F[M]=1):** fraction = F>>1 with new bit0 = F[1]|F[0] (sticky jam). Exponent = E+1, modulo 2^EXP_WIDTH.
- **Normalised (F[M:M-1]=01):** fraction and exponent pass through unchanged.
- **Underflow (F[M:M-1]=00, F≠0):**
  - L = leading-zero count of F[M-1:0], range 1..M-1.
  - Shift S = L, or the clamped value when clamping is enabled.
  - fraction = F<<S with zero fill; exponent = E−S.
  - out_underflow is set per Configuration.
- **Zero (F=0):** fraction = 0, exponent = 0, out_zero=1, out_underflow=0.

L is computed over all M bits and has width $clog2(FRAC_WIDTH).

Pipeline:
- Stage 1 registers the operands, the case decode and S.
- Stage 2 registers the shifted fraction, the exponent, and the flags.

Reset clears s1_valid, s2_valid and out_valid to 0. All data outputs reset to 0.

## Timing
- Latency is exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no stall.
- Throughput is one operation per cycle.
- Stage advance rules:
  - s2_load = !s2_valid | out_ready.
  - s1_load = !s1_valid | s2_load.
  - in_ready = s1_load. This is combinational from out_ready; no skid buffer.
- Output hold: while out_valid & !out_ready, all out_* signals hold stable. A consumer that is never ready stalls the pipeline after 2 accepted operations.
- Transfer rule: a transfer happens only when valid & ready are both high in the same cycle. Order is strictly FIFO and no operation is dropped or duplicated.
- Simultaneous events: when a transfer out and a transfer in occur in the same cycle, both stages advance.
- Reset during operation: reset asserted with operations in flight discards them. out_valid=0 in the cycle after reset is sampled. in_ready=1 while reset is held.
- Arithmetic: all exponent arithmetic is unsigned modulo 2^EXP_WIDTH. Borrow is detected as E < S.

## Configuration
Macro: FP_NORMALIZER_DENORM_CLAMP_EN.
- **Defined:** the shift is S = min(L, E−1) when E≥1, and S = 0 when E=0. The exponent therefore never drops below 1; the result stays subnormal-aligned. out_underflow=1 when S<L.
- **Undefined:** S = L. The exponent wraps on borrow, and out_underflow=1 when E<L.

## Test plan
- **Overflow:** F = bit48|bit0, E=100, out_ready=1 → 2 cycles later fraction = bit47|bit0, E=101, zero=0, underflow=0.
- **Normalised:** F = bit47|bit3, E=5 → identical fraction, E=5.
- **Underflow:** F = bit44 only, E=100 → fraction = bit47 only, E=97, underflow=0.
- **Zero:** F=0, E=200, tag=9 → fraction 0, E 0, zero=1, tag=9.
- **Clamp:** F = bit40 only (L=7), E=4.
  - Macro defined → E=1, fraction = bit43, underflow=1.
  - Macro undefined → E=1021, fraction = bit47, underflow=1.
- **Backpressure/reset:** 4 back-to-back inputs with tags 1..4, out_ready=0 for cycles 2–6.
  - Required: in_ready drops after 2 acceptances, out_* are held stable, and tags emerge in order 1,2,3,4.
  - Then assert reset with 2 operations in flight → out_valid=0 on the next cycle and no stale output afterwards.
